// File: rtl/nor12_bist_pkg.sv
// rtl/nor12_bist_pkg.sv - shared types and constants for the nor12 BIST driver
//   state_t  : sweep FSM states
//   VEC_W    : stimulus vector width (one bit per NOR input)
//   LAST_VEC : final vector of a sweep
//   ERR_W    : mismatch counter width (holds 0..4096)
package nor12_bist_pkg;

  localparam int VEC_W = 12;
  localparam int ERR_W = 13;
  localparam logic [VEC_W-1:0] LAST_VEC = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/nor12_bist_settle_timer.sv
// rtl/nor12_bist_settle_timer.sv - 8-bit up/down settle counter with clear and terminal flag
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : count enable
//   up       : 1 counts up, 0 counts down
//   term     : terminal value
//   tc       : high while the count equals term
module nor12_bist_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       up,
  input  logic [7:0] term,
  output logic       tc
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = up ? (cnt_q + 8'd1) : (cnt_q - 8'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/nor12_bist.sv
// rtl/nor12_bist.sv - exhaustive sweep BIST driver for the 12-input NOR cell
// Sweeps vec through 0..4095, holds each vector SETTLE_CYC cycles, then
// samples w_in against ~|vec and counts mismatches.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start          : begin a sweep (honoured in IDLE or DONE only)
//   w_in           : NOR cell output under test
//   vec            : stimulus to the cell (vec[0] -> a ... vec[11] -> l)
//   busy           : sweep in progress
//   done           : sweep finished
//   pass           : done with zero mismatches
//   err_count      : mismatching vectors so far
//   first_fail_vec : first failing vector (NOR12_BIST_FAILCAP_EN only)
//   fail_valid     : first_fail_vec holds a capture (NOR12_BIST_FAILCAP_EN only)
// Optional feature macro: NOR12_BIST_FAILCAP_EN
import nor12_bist_pkg::*;

module nor12_bist #(
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             w_in,
  output logic [VEC_W-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef NOR12_BIST_FAILCAP_EN
  ,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             fail_valid
`endif
);

  localparam logic [7:0] TERM = 8'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic             exp_bit, mismatch;
`ifdef NOR12_BIST_FAILCAP_EN
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic             fv_q, fv_d;
`endif

  nor12_bist_settle_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .up   (1'b1),
    .term (TERM),
    .tc   (tmr_tc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SETTLE;
      SETTLE:     if (tmr_tc) state_d = SAMPLE;
      SAMPLE:     state_d = (vec_q == LAST_VEC) ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end

  // Case-inequality so that an X or Z from the cell is scored as a failure.
  assign exp_bit  = ~|vec_q;
  assign mismatch = (w_in !== exp_bit);

  // Datapath: vector register, error counter, settle timer control
  always_comb begin
    vec_d   = vec_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
`ifdef NOR12_BIST_FAILCAP_EN
    ffv_d   = ffv_q;
    fv_d    = fv_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          tmr_clr = 1'b1;
`ifdef NOR12_BIST_FAILCAP_EN
          ffv_d   = '0;
          fv_d    = 1'b0;
`endif
        end
      end
      SETTLE: tmr_en = 1'b1;
      SAMPLE: begin
        // Timer restarts from zero for the next vector's settle window.
        tmr_clr = 1'b1;
        if (mismatch) begin
          err_d = err_q + 13'd1;
`ifdef NOR12_BIST_FAILCAP_EN
          if (!fv_q) begin
            ffv_d = vec_q;
            fv_d  = 1'b1;
          end
`endif
        end
        if (vec_q != LAST_VEC) vec_d = vec_q + 12'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      err_q <= '0;
`ifdef NOR12_BIST_FAILCAP_EN
      ffv_q <= '0;
      fv_q  <= 1'b0;
`endif
    end else begin
      vec_q <= vec_d;
      err_q <= err_d;
`ifdef NOR12_BIST_FAILCAP_EN
      ffv_q <= ffv_d;
      fv_q  <= fv_d;
`endif
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == SETTLE) || (state_q == SAMPLE);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (err_q == '0);
  end

  assign vec       = vec_q;
  assign err_count = err_q;
`ifdef NOR12_BIST_FAILCAP_EN
  assign first_fail_vec = ffv_q;
  assign fail_valid     = fv_q;
`endif

endmodule

// File: tb/tb_nor12_bist.sv
// tb/tb_nor12_bist.sv - self-checking bench for nor12_bist with a cycle-arithmetic reference model
module tb_nor12_bist;

  localparam int S     = 2;
  localparam int PER   = S + 1;
  localparam int SWEEP = 4096 * PER;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        w_in;
  logic [11:0] vec;
  logic        busy, done, pass;
  logic [12:0] err_count;
`ifdef NOR12_BIST_FAILCAP_EN
  logic [11:0] first_fail_vec;
  logic        fail_valid;
`endif

  nor12_bist #(.SETTLE_CYC(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .w_in      (w_in),
    .vec       (vec),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
`ifdef NOR12_BIST_FAILCAP_EN
    ,
    .first_fail_vec (first_fail_vec),
    .fail_valid     (fail_valid)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;   // 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 random faults
  bit fault_tbl [4096];
  int n_faults  = 0;
  int first_flt = -1;

  always @(posedge clk) cyc++;

  function automatic bit cell_out(input int md, input int v);
    case (md)
      0:       return (v == 0);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return (v == 0) ^ fault_tbl[v];
    endcase
  endfunction

  // Cell model driven from the stimulus the DUT presents.
  always @(vec or mode) w_in = cell_out(mode, int'(vec));

  // Reference model: m_t counts edges since the start edge; vector k is
  // presented during edges k*PER .. k*PER+PER-1 and scored at edge (k+1)*PER.
  int m_run = 0;   // 0 idle, 1 running, 2 done
  int m_t   = 0;
  int m_err = 0;
  int m_vec = 0;
  int m_v   = 0;
  int m_ffv = 0;
  bit m_fv  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_t = 0; m_err = 0; m_vec = 0; m_ffv = 0; m_fv = 1'b0;
    end else if (m_run != 1 && start) begin
      m_run = 1; m_t = 0; m_err = 0; m_vec = 0; m_ffv = 0; m_fv = 1'b0;
    end else if (m_run == 1) begin
      m_t++;
      if (m_t % PER == 0) begin
        m_v = m_t / PER - 1;
        if (cell_out(mode, m_v) != (m_v == 0)) begin
          m_err++;
          if (!m_fv) begin
            m_fv  = 1'b1;
            m_ffv = m_v;
          end
        end
        if (m_v == 4095) m_run = 2;
        else m_vec = m_t / PER;
      end
    end
  end

  always @(negedge clk) begin
    total++;
    if (vec !== 12'(m_vec) || busy !== (m_run == 1) || done !== (m_run == 2) ||
        pass !== (m_run == 2 && m_err == 0) || err_count !== 13'(m_err)
`ifdef NOR12_BIST_FAILCAP_EN
        || first_fail_vec !== 12'(m_ffv) || fail_valid !== m_fv
`endif
       ) begin
      bad++;
      $display("FAIL cycle %0d: got vec=%h busy=%b done=%b pass=%b err=%0d want vec=%h busy=%0d done=%0d pass=%0d err=%0d",
               cyc, vec, busy, done, pass, err_count, 12'(m_vec), m_run == 1, m_run == 2,
               (m_run == 2 && m_err == 0), m_err);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int se);
    int n = 0;
    while (done !== 1'b1 && n < SWEEP + 100) begin
      step();
      n++;
    end
    check({name, " done_seen"}, 32'(done), 1);
    check({name, " latency"}, cyc - se, SWEEP);
  endtask

  task automatic pulse_start(output int se);
    step();
    start = 1'b1;
    se = cyc + 1;
    step();
    start = 1'b0;
  endtask

  int se;
  int n;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      fault_tbl[i] = ($urandom_range(0, 31) == 0);
      if (fault_tbl[i]) begin
        n_faults++;
        if (first_flt < 0) first_flt = i;
      end
    end

    #1 rst = 1'b1;
    repeat (3) step();
    check("rst vec", 32'(vec), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst pass", 32'(pass), 0);
    check("rst err", 32'(err_count), 0);
    rst = 1'b0;
    repeat (4) step();
    check("idle busy", 32'(busy), 0);

    // Golden sweep with stray start pulses while busy
    mode = 0;
    pulse_start(se);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(5, 3000)) step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done("golden", se);
    check("golden err", 32'(err_count), 0);
    check("golden pass", 32'(pass), 1);
    check("golden last vec", 32'(vec), 32'h0FFF);

    // Stuck-at-0, started by holding start high in DONE
    mode = 1;
    start = 1'b1;
    se = cyc + 1;
    step();
    check("s0 restart busy", 32'(busy), 1);
    check("s0 restart vec", 32'(vec), 0);
    wait_done("stuck0", se);
    check("stuck0 err", 32'(err_count), 1);
    check("stuck0 pass", 32'(pass), 0);
`ifdef NOR12_BIST_FAILCAP_EN
    check("stuck0 ffv", 32'(first_fail_vec), 0);
    check("stuck0 fv", 32'(fail_valid), 1);
`endif

    // start still high: back-to-back sweep with stuck-at-1
    mode = 2;
    se = cyc + 1;
    step();
    check("b2b busy", 32'(busy), 1);
    check("b2b err cleared", 32'(err_count), 0);
    check("b2b done low", 32'(done), 0);
    start = 1'b0;
    wait_done("stuck1", se);
    check("stuck1 err", 32'(err_count), 4095);
    check("stuck1 pass", 32'(pass), 0);
`ifdef NOR12_BIST_FAILCAP_EN
    check("stuck1 ffv", 32'(first_fail_vec), 1);
`endif

    // Abort mid-sweep at vec 0x123
    mode = 0;
    pulse_start(se);
    n = 0;
    while (vec !== 12'h123 && n < 2000) begin
      step();
      n++;
    end
    check("abort reached", 32'(vec), 32'h123);
    check("abort busy before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort vec", 32'(vec), 0);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort pass", 32'(pass), 0);
    check("abort err", 32'(err_count), 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    check("post-abort idle", 32'(busy), 0);

    pulse_start(se);
    wait_done("restart", se);
    check("restart err", 32'(err_count), 0);
    check("restart pass", 32'(pass), 1);

    // Random fault pattern
    mode = 3;
    pulse_start(se);
    wait_done("random", se);
    check("random err", 32'(err_count), n_faults);
    check("random pass", 32'(pass), (n_faults == 0) ? 1 : 0);
`ifdef NOR12_BIST_FAILCAP_EN
    if (n_faults > 0) check("random ffv", 32'(first_fail_vec), first_flt);
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nor12_bist.md
# nor12_bist

Built-in self-test driver for the 12-input switch-level NOR cell. It drives every one of the 4096 input combinations onto the cell's inputs. For each one it waits a programmable settle window to cover the transistor rise/fall delays, then samples the cell output and compares it with the expected NOR value. It sits beside the NOR instance in the lab top level and reports pass/fail plus a mismatch count.

## Interface
Parameters:
- SETTLE_CYC, 4, clock cycles each vector is held before sampling; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- w_in  input  1  output of the NOR cell under test.
- vec  output  12  stimulus to the cell: vec[0]→a, vec[1]→b, … vec[11]→l.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when err_count == 0; low otherwise.
- err_count  output  13  number of mismatching vectors, 0..4096.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: outputs hold their values; if start=1 → SETTLE, with vec=0, settle counter=0, err_count=0.
- SETTLE: the settle counter increments each cycle. When the counter equals SETTLE_CYC-1 → SAMPLE. SETTLE therefore lasts exactly SETTLE_CYC cycles.
- SAMPLE: expected = ~|vec.
  - If w_in != expected, err_count increments.
  - If vec == 12'hFFF → DONE.
  - Otherwise vec increments by 1, the counter clears, and the state returns to SETTLE.
- DONE: done=1 and pass=(err_count==0). The block holds until start=1, which restarts exactly as from IDLE.
- start is ignored in SETTLE and SAMPLE; a running sweep cannot be restarted.
- err_count cannot overflow, since there are at most 4096 mismatches in 13 bits; no saturation logic is needed.
- vec is a registered output that changes only on the edge entering SETTLE, so it is stable for the whole settle and sample interval.
- w_in is sampled directly with no synchronizer. The settle window is the only protection, and picking SETTLE_CYC is the integrator's responsibility.
- An X or Z on w_in in SAMPLE counts as a mismatch.

## Timing
- Reset (asynchronous, immediate): state=IDLE, vec=0, err_count=0, busy=0, done=0, pass=0; plus the feature outputs below when the feature is compiled in.
- Per vector: SETTLE_CYC+1 cycles.
- The edge that samples start puts the block in SETTLE with vec=0. done rises 4096·(SETTLE_CYC+1) edges later; for SETTLE_CYC=4 that is 20480.
- busy and done are never high together; both are low only in IDLE.
- Reset asserted mid-sweep aborts immediately. After release the block sits in IDLE and needs a new start.
- start held high continuously in DONE restarts on the next edge, giving back-to-back sweeps.

## Configuration
- NOR12_BIST_FAILCAP_EN defined: adds outputs first_fail_vec (12 bits) and fail_valid (1 bit), both reset to 0 and cleared on start.
  - On the first mismatch of a sweep, the failing vec is latched and fail_valid is set.
  - Later mismatches do not overwrite the latched vector.
- NOR12_BIST_FAILCAP_EN undefined: those ports and registers are absent, and all other behaviour is identical.

## Structure
- Package nor12_bist_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - VEC_W=12;
  - LAST_VEC=12'hFFF;
  - ERR_W=13.
- One sub-module, nor12_bist_settle_timer: an 8-bit down/up counter with clear and a terminal-count flag. The FSM, vector register and error counter stay in the top module.

## Test plan
- Golden cell, SETTLE_CYC=4, start pulse → done after 20480 edges, err_count=0, pass=1; vec visits 0..4095 in order.
- Stuck-at-0 model on w_in → err_count=1 (only vec=0 expects 1), pass=0; with NOR12_BIST_FAILCAP_EN, first_fail_vec=12'h000.
- Stuck-at-1 model on w_in → err_count=4095, pass=0; with NOR12_BIST_FAILCAP_EN, first_fail_vec=12'h001.
- Golden cell with SETTLE_CYC=1 and a 10 ns clock → err_count reflects delay violations. Repeat with SETTLE_CYC=2 → err_count=0.
- rst asserted at vec=12'h123 in SETTLE → all outputs 0 immediately. After release, a start pulse restarts from vec=0 and ends with pass=1.
- Extra start pulse during busy → no effect, and done still arrives at edge 20480. start held high in DONE → second sweep begins on the next edge with err_count cleared.
